// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the pipeline control blocks.
//   hz_state_t  - hazard controller state (RUN, LU_STALL, MEM_WAIT)
//   REG_ADDR_W  - architectural register index width
//   X0          - index of the hard-wired zero register
//   BUB_W       - width of the load-use bubble counter (LOAD_BUBBLES <= 3)
package core_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int BUB_W      = 2;

    localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hz_event_counter.sv
// hz_event_counter: free-running event counter that wraps modulo 2^W.
// Ports:
//   clk   - core clock
//   rst   - synchronous active-high reset, clears the count
//   inc   - count one event this cycle
//   count - current count (registered)
module hz_event_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: increment on event, natural wrap at all-ones.
    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use / memory-wait / redirect stall and flush controller.
// Decisions are Mealy (current state + current inputs); state and event
// counters update on the rising clock edge.
// Ports:
//   clk, rst                     - core clock, synchronous active-high reset
//   ifid_src1/2, ifid_use1/2     - source registers of ID instruction and use flags
//   idex_memread, idex_dest      - EX instruction is a load, and its rd
//   ex_redirect                  - EX resolved a taken branch / jump
//   dmem_req, dmem_ready         - MEM access outstanding / completing
//   pc_en .. memwb_en            - pipeline register enables
//   ifid_flush .. memwb_flush    - bubble insertion for the named registers
//   stall_cnt, flush_cnt         - cycles with PC held, redirect flushes taken
module hazard_unit
    import core_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ifid_src1,
    input  logic [REG_ADDR_W-1:0] ifid_src2,
    input  logic                  ifid_use1,
    input  logic                  ifid_use2,
    input  logic                  idex_memread,
    input  logic [REG_ADDR_W-1:0] idex_dest,
    input  logic                  ex_redirect,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  memwb_flush,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [BUB_W-1:0] BUB_ZERO   = 2'd0;
    localparam logic [BUB_W-1:0] BUB_ONE    = 2'd1;
    localparam logic [BUB_W-1:0] BUB_RELOAD = BUB_W'(LOAD_BUBBLES - 1);
    localparam hz_state_t        HIT_NEXT   = (LOAD_BUBBLES > 1) ? LU_STALL : RUN;

    hz_state_t         state_q, state_d;
    logic [BUB_W-1:0]  bub_cnt_q, bub_cnt_d;
    logic              pending_q, pending_d;
    logic              lu_hit;
    logic              mem_wait;
    logic              stall_inc;
    logic              flush_inc;

    assign lu_hit = idex_memread & (idex_dest != X0) &
                    (((idex_dest == ifid_src1) & ifid_use1) |
                     ((idex_dest == ifid_src2) & ifid_use2));

    assign mem_wait = dmem_req & ~dmem_ready;

    // Mealy decision: enables, flushes and next state from state + inputs.
    // Within LU_STALL, bub_cnt_q counts stall cycles still owed including
    // the current one; it is frozen while memory holds the pipe.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        state_d     = state_q;
        bub_cnt_d   = bub_cnt_q;
        pending_d   = pending_q;
        flush_inc   = 1'b0;

        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
            state_d     = RUN;
            bub_cnt_d   = BUB_ZERO;
            pending_d   = 1'b0;
        end else if (mem_wait) begin
            // Whole pipe frozen; MEM result invalid so WB gets a bubble.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            memwb_flush = 1'b1;
            state_d     = MEM_WAIT;
            pending_d   = pending_q | ex_redirect;
        end else if (state_q == MEM_WAIT) begin
            pending_d = 1'b0;
            if (pending_q | ex_redirect) begin
                // Deferred redirect fires now and cancels any saved stall.
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                flush_inc  = 1'b1;
                bub_cnt_d  = BUB_ZERO;
                state_d    = RUN;
            end else if (bub_cnt_q != BUB_ZERO) begin
                state_d = LU_STALL;
            end else begin
                state_d = RUN;
            end
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
            bub_cnt_d  = BUB_ZERO;
            state_d    = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (lu_hit) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        bub_cnt_d  = BUB_RELOAD;
                        state_d    = HIT_NEXT;
                    end else begin
                        state_d = RUN;
                    end
                end
                LU_STALL: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    if (bub_cnt_q > BUB_ONE) begin
                        bub_cnt_d = bub_cnt_q - BUB_ONE;
                        state_d   = LU_STALL;
                    end else begin
                        bub_cnt_d = BUB_ZERO;
                        state_d   = RUN;
                    end
                end
                default: begin
                    // Unreachable encoding: hold the pipe one cycle and resync.
                    pc_en     = 1'b0;
                    ifid_en   = 1'b0;
                    idex_en   = 1'b0;
                    exmem_en  = 1'b0;
                    memwb_en  = 1'b0;
                    bub_cnt_d = BUB_ZERO;
                    pending_d = 1'b0;
                    state_d   = RUN;
                end
            endcase
        end
    end

    assign stall_inc = ~pc_en & ~rst;

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            bub_cnt_q <= BUB_ZERO;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bub_cnt_q <= bub_cnt_d;
            pending_q <= pending_d;
        end
    end

    hz_event_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    hz_event_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances share stimulus (A: 1 bubble, 4-bit
// counters; B: 3 bubbles, 32-bit counters). A behavioural model tracks
// owed stall cycles, memory-wait and deferred-redirect status per instance.
module tb_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] ifid_src1, ifid_src2, idex_dest;
    logic       ifid_use1, ifid_use2, idex_memread, ex_redirect, dmem_req, dmem_ready;

    logic a_pc_en, a_ifid_en, a_idex_en, a_exmem_en, a_memwb_en;
    logic a_ifid_flush, a_idex_flush, a_memwb_flush;
    logic [3:0] a_stall_cnt, a_flush_cnt;
    logic b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en;
    logic b_ifid_flush, b_idex_flush, b_memwb_flush;
    logic [31:0] b_stall_cnt, b_flush_cnt;

    hazard_unit #(.LOAD_BUBBLES(1), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .ifid_src1(ifid_src1), .ifid_src2(ifid_src2),
        .ifid_use1(ifid_use1), .ifid_use2(ifid_use2),
        .idex_memread(idex_memread), .idex_dest(idex_dest),
        .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(a_pc_en), .ifid_en(a_ifid_en), .idex_en(a_idex_en),
        .exmem_en(a_exmem_en), .memwb_en(a_memwb_en),
        .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush), .memwb_flush(a_memwb_flush),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    hazard_unit #(.LOAD_BUBBLES(3), .CNT_W(32)) u_dut_b (
        .clk(clk), .rst(rst),
        .ifid_src1(ifid_src1), .ifid_src2(ifid_src2),
        .ifid_use1(ifid_use1), .ifid_use2(ifid_use2),
        .idex_memread(idex_memread), .idex_dest(idex_dest),
        .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(b_pc_en), .ifid_en(b_ifid_en), .idex_en(b_idex_en),
        .exmem_en(b_exmem_en), .memwb_en(b_memwb_en),
        .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush), .memwb_flush(b_memwb_flush),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance: stall cycles still owed, in-wait flag,
    // redirect remembered during a wait, and event counts.
    int          m_left [2];
    bit          m_wait [2];
    bit          m_pend [2];
    logic [31:0] m_sc   [2];
    logic [31:0] m_fc   [2];
    int          m_nbub [2];
    logic [31:0] m_mask [2];
    bit          primed;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare both DUTs against the model for the current inputs, then advance the model.
    task automatic check_step();
        logic       hit, wt_now;
        logic [7:0] e, got;
        logic [31:0] gsc, gfc;
        hit = idex_memread && (idex_dest != 5'd0) &&
              (((idex_dest == ifid_src1) && ifid_use1) || ((idex_dest == ifid_src2) && ifid_use2));
        wt_now = dmem_req && !dmem_ready;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                got = {a_pc_en, a_ifid_en, a_idex_en, a_exmem_en, a_memwb_en,
                       a_ifid_flush, a_idex_flush, a_memwb_flush};
                gsc = {28'd0, a_stall_cnt};
                gfc = {28'd0, a_flush_cnt};
            end else begin
                got = {b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en,
                       b_ifid_flush, b_idex_flush, b_memwb_flush};
                gsc = b_stall_cnt;
                gfc = b_flush_cnt;
            end
            if (primed) begin
                chk((i == 0) ? "stall_cnt_a" : "stall_cnt_b", gsc, m_sc[i]);
                chk((i == 0) ? "flush_cnt_a" : "flush_cnt_b", gfc, m_fc[i]);
            end
            // e = {pc,ifid,idex,exmem,memwb enables, ifid,idex,memwb flushes}
            if (rst) begin
                e = 8'b00000_111;
                m_left[i] = 0; m_wait[i] = 1'b0; m_pend[i] = 1'b0;
                m_sc[i] = 32'd0; m_fc[i] = 32'd0;
            end else if (wt_now) begin
                e = 8'b00000_001;
                m_wait[i] = 1'b1;
                m_pend[i] = m_pend[i] | ex_redirect;
            end else if (m_wait[i]) begin
                e = 8'b11111_000;
                if (m_pend[i] || ex_redirect) begin
                    e = 8'b11111_110;
                    m_fc[i] = m_fc[i] + 32'd1;
                    m_left[i] = 0;
                end
                m_wait[i] = 1'b0;
                m_pend[i] = 1'b0;
            end else if (ex_redirect) begin
                e = 8'b11111_110;
                m_fc[i] = m_fc[i] + 32'd1;
                m_left[i] = 0;
            end else if (m_left[i] > 0) begin
                e = 8'b00111_010;
                m_left[i]--;
            end else if (hit) begin
                e = 8'b00111_010;
                m_left[i] = m_nbub[i] - 1;
            end else begin
                e = 8'b11111_000;
            end
            if (!rst && !e[7]) m_sc[i] = m_sc[i] + 32'd1;
            m_sc[i] = m_sc[i] & m_mask[i];
            m_fc[i] = m_fc[i] & m_mask[i];
            chk((i == 0) ? "outs_a" : "outs_b", {24'd0, got}, {24'd0, e});
        end
        if (rst) primed = 1'b1;
    endtask

    task automatic cyc(input logic r, input logic [4:0] s1, input logic u1,
                       input logic [4:0] s2, input logic u2, input logic mr,
                       input logic [4:0] d, input logic rd, input logic rq, input logic rdy);
        rst = r; ifid_src1 = s1; ifid_use1 = u1; ifid_src2 = s2; ifid_use2 = u2;
        idex_memread = mr; idex_dest = d; ex_redirect = rd; dmem_req = rq; dmem_ready = rdy;
        @(negedge clk);
        check_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_rst();
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hitc();
        cyc(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic memc(input logic rd, input logic rq, input logic rdy);
        cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, rd, rq, rdy);
    endtask

    initial begin
        m_nbub[0] = 1; m_nbub[1] = 3;
        m_mask[0] = 32'h0000_000F; m_mask[1] = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0; m_wait[i] = 1'b0; m_pend[i] = 1'b0;
            m_sc[i] = 32'd0; m_fc[i] = 32'd0;
        end
        primed = 1'b0;

        // Reset state and basic load-use hit.
        do_rst(); do_rst();
        chk("rst_stall_a", {28'd0, a_stall_cnt}, 32'd0);
        chk("rst_flush_b", b_flush_cnt, 32'd0);
        hitc(); idle(3);
        chk("lu1_stall_a", {28'd0, a_stall_cnt}, 32'd1);
        chk("lu3_stall_b", b_stall_cnt, 32'd3);

        // rd = x0 and unused source never stall; rs2 match does.
        do_rst();
        cyc(1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("nohaz_stall_a", {28'd0, a_stall_cnt}, 32'd0);
        chk("nohaz_stall_b", b_stall_cnt, 32'd0);
        cyc(1'b0, 5'd7, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("rs2_stall_b", b_stall_cnt, 32'd3);

        // Memory wait inside the second bubble.
        do_rst();
        hitc();
        memc(1'b0, 1'b1, 1'b0); memc(1'b0, 1'b1, 1'b0); memc(1'b0, 1'b1, 1'b1);
        idle(3);
        chk("luwait_stall_b", b_stall_cnt, 32'd5);
        chk("luwait_stall_a", {28'd0, a_stall_cnt}, 32'd3);

        // Redirect during a 4-cycle memory wait is deferred to the exit cycle.
        do_rst();
        memc(1'b1, 1'b1, 1'b0); memc(1'b0, 1'b1, 1'b0); memc(1'b0, 1'b1, 1'b0); memc(1'b0, 1'b1, 1'b0);
        chk("defer_noflush_b", b_flush_cnt, 32'd0);
        memc(1'b0, 1'b0, 1'b0);
        idle(2);
        chk("defer_flush_a", {28'd0, a_flush_cnt}, 32'd1);
        chk("defer_flush_b", b_flush_cnt, 32'd1);

        // Redirect and load-use in the same cycle: flush only.
        do_rst();
        cyc(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("redir_hit_stall_b", b_stall_cnt, 32'd0);
        chk("redir_hit_flush_b", b_flush_cnt, 32'd1);

        // Redirect during LU_STALL abandons the stall.
        do_rst();
        hitc(); memc(1'b1, 1'b0, 1'b0); idle(2);
        chk("redir_lu_stall_b", b_stall_cnt, 32'd1);

        // Reset mid-stall and mid-wait with pending redirect.
        do_rst();
        hitc(); do_rst(); idle(2);
        chk("rst_lu_stall_b", b_stall_cnt, 32'd0);
        memc(1'b1, 1'b1, 1'b0); do_rst(); idle(2);
        chk("rst_wait_flush_b", b_flush_cnt, 32'd0);

        // Counter wrap on the 4-bit instance.
        do_rst();
        for (int k = 0; k < 16; k++) hitc();
        chk("wrap_stall_a", {28'd0, a_stall_cnt}, 32'd0);
        chk("wrap_stall_b", b_stall_cnt, 32'd16);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard detection and stall/flush controller for the five-stage RISC-V core. Complements the forwarding unit: where bypassing cannot resolve a dependency (load-use), or the data memory is not ready, or EX redirects the PC, this block holds or bubbles pipeline registers. Sits beside the ID/EX boundary and drives the enable/flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers; also keeps stall and flush event counters.

## Interface
- LOAD_BUBBLES, 1: bubbles inserted per load-use hazard; legal 1..3
- CNT_W, 32: event counter width
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ifid_src1, ifid_src2  in  5 each  rs1/rs2 of instruction in ID
- ifid_use1, ifid_use2  in  1 each  ID instruction actually reads rs1/rs2
- idex_memread  in  1  instruction in EX is a load
- idex_dest  in  5  rd of instruction in EX
- ex_redirect  in  1  branch taken / jump resolved in EX
- dmem_req  in  1  MEM stage access outstanding this cycle
- dmem_ready  in  1  data memory completes access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables
- ifid_flush, idex_flush, memwb_flush  out  1 each  load bubble (NOP, no writeback)
- stall_cnt, flush_cnt  out  CNT_W each  event counters

## Operation
- FSM states: RUN, LU_STALL, MEM_WAIT.
- Load-use hit = idex_memread & idex_dest != 0 & ((idex_dest == ifid_src1 & ifid_use1) | (idex_dest == ifid_src2 & ifid_use2)). rd = x0 never hazards.
- Outputs are Mealy: decided from current state and current inputs, same cycle.
- Priority each cycle: memory wait > redirect > load-use.
- Memory wait (dmem_req & !dmem_ready), any state: all five enables 0, memwb_flush 1, other flushes 0; go/stay MEM_WAIT. If ex_redirect asserted during wait, set pending_redirect.
- MEM_WAIT exit (dmem_ready or !dmem_req): enables 1; if pending_redirect or ex_redirect, ifid_flush = idex_flush = 1 and clear pending; return to RUN (or LU_STALL if a saved bubble count remains, see below).
- Redirect in RUN/LU_STALL: all enables 1, ifid_flush = idex_flush = 1, flush_cnt += 1; abandons any load-use stall (bubble counter cleared), next state RUN.
- Load-use hit in RUN: pc_en = ifid_en = 0, idex_flush = 1, other enables 1; bub_cnt <= LOAD_BUBBLES-1; next LU_STALL if LOAD_BUBBLES > 1, else RUN.
- LU_STALL: same outputs as hit; bub_cnt decrements; leave to RUN when bub_cnt == 0 at cycle start. Memory wait during LU_STALL freezes bub_cnt and resumes it afterwards.
- Idle RUN, no events: all enables 1, all flushes 0.
- stall_cnt += 1 on every cycle with pc_en == 0 (rst excluded). Counters wrap modulo 2^CNT_W.

## Timing
- Reset (rst high at clk edge): state RUN, bub_cnt 0, pending_redirect 0, counters 0. While rst high, outputs: all enables 0, ifid_flush = idex_flush = memwb_flush = 1.
- Zero-cycle decision latency; state/counters update on rising edge.
- Load-use with LOAD_BUBBLES = N: exactly N consecutive cycles of pc_en = 0, absent memory waits or redirects.
- Redirect flush is exactly one cycle per redirect event, including a deferred one.
- Reset mid-stall or mid-wait: all state dropped; pending redirect discarded.

## Structure
- Shared package core_pkg: hz_state_t enum (RUN, LU_STALL, MEM_WAIT), REG_ADDR_W = 5, X0 constant.
- Sub-module hz_event_counter (enable, sync reset, wrap), instantiated twice.
- Hazard compare is combinational in-module; no separate sub-module.

## Test plan
- LOAD_BUBBLES=1: idex_memread=1, idex_dest=5, ifid_src1=5, use1=1 -> one cycle pc_en=ifid_en=0, idex_flush=1; next cycle idle; stall_cnt=1.
- Same with idex_dest=0, or use1=0 -> no stall, all enables 1.
- LOAD_BUBBLES=3 hit, then dmem_req=1, dmem_ready=0 for 2 cycles in second bubble -> total pc_en=0 for 5 cycles, memwb_flush high only during 2 wait cycles.
- ex_redirect during 4-cycle memory wait -> no flush during wait; on exit cycle ifid_flush=idex_flush=1 once; flush_cnt=1.
- Redirect and load-use hit same cycle -> flush only, no stall, state RUN.
- rst asserted in LU_STALL -> next cycle after release RUN, counters 0; CNT_W=4 wrap: 16 stalls -> stall_cnt=0.
